// File: rtl/div_pkg.sv
// Shared constants for the SRT divider operand path.
// Packet layout (default WIDTH=32):
//   [65]    select   0 = integer, 1 = fp32
//   [64]    sign     1 = sign-magnitude divide
//   [63:32] dividend
//   [31:0]  divisor
package div_pkg;

   localparam int WIDTH      = 32;
   localparam int DATA_WIDTH = 2*WIDTH + 2;

   localparam int SEL_BIT    = 65;
   localparam int SIGN_BIT   = 64;
   localparam int DVD_MSB    = 63;
   localparam int DVD_LSB    = 32;
   localparam int DVS_MSB    = 31;
   localparam int DVS_LSB    = 0;

   localparam int BYTE_W     = 8;

   typedef struct packed {
      logic              sel;
      logic              sign;
      logic [WIDTH-1:0]  dividend;
      logic [WIDTH-1:0]  divisor;
   } div_pkt_t;

   // Number of bytes needed to carry both operands.
   function automatic int bytes_per_pkt(input int w);
      return (2*w) / BYTE_W;
   endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Operand packet FIFO, first-word-fall-through.
// When empty, rd_data_o keeps showing the last entry read out (0 after
// reset) so the divider-facing head fields never show stale RAM contents.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wr_en_i      write request; accepted when not full or when reading
//   wr_data_i    packet to write
//   rd_en_i      pop head (ignored when empty)
//   rd_data_o    head packet
//   full_o       all BUFFER_DEPTH entries used
//   empty_o      no entries
//   count_o      entries held, 0..BUFFER_DEPTH
module div_op_fifo
   import div_pkg::*;
#(
   parameter int DATA_WIDTH       = div_pkg::DATA_WIDTH,
   parameter int BUFFER_DEPTH     = 4,
   parameter int LOG_BUFFER_DEPTH = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en_i,
   input  logic [DATA_WIDTH-1:0]       wr_data_i,
   input  logic                        rd_en_i,
   output logic [DATA_WIDTH-1:0]       rd_data_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [LOG_BUFFER_DEPTH-1:0] count_o
);

   localparam int AW = LOG_BUFFER_DEPTH - 1;

   logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
   logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]       last_q, last_d;
   logic                        do_wr, do_rd;

   // Pointers carry an extra wrap bit: equal = empty, equal except wrap = full.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;

   assign do_rd = rd_en_i & ~empty_o;
   assign do_wr = wr_en_i & (~full_o | do_rd);

   assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
      end
   end

   // Storage needs no reset: it is only visible while non-empty.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/div_in_collector.sv
// Byte-serial operand collector for the SRT divider.
// Eight bytes (dividend then divisor, MSB first) plus sign/select are
// assembled into one packet and queued for the divider.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   data_in_in    input byte, stable while push_in high
//   push_in       byte strobe, one capture per rising edge
//   sign, select  mode bits, latched with the last byte
//   op_valid      head packet present
//   op_ready      divider takes the head this cycle
//   op_dividend, op_divisor, op_sign, op_select   head packet fields
//   op_div_zero   head divisor is zero
//   fifo_count    packets queued
//   overflow      sticky, a complete packet was dropped
module div_in_collector
   import div_pkg::*;
#(
   parameter int WIDTH            = div_pkg::WIDTH,
   parameter int DATA_WIDTH       = 2*WIDTH + 2,
   parameter int BUFFER_DEPTH     = 4,
   parameter int LOG_BUFFER_DEPTH = 3,
   parameter int IDLE_TIMEOUT     = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  data_in_in,
   input  logic                        push_in,
   input  logic                        sign,
   input  logic                        select,
   output logic                        op_valid,
   input  logic                        op_ready,
   output logic [WIDTH-1:0]            op_dividend,
   output logic [WIDTH-1:0]            op_divisor,
   output logic                        op_sign,
   output logic                        op_select,
   output logic                        op_div_zero,
   output logic [LOG_BUFFER_DEPTH-1:0] fifo_count,
   output logic                        overflow
);

   localparam int NBYTES = bytes_per_pkt(WIDTH);
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int ASM_W  = 2*WIDTH - BYTE_W;
   localparam int TMR_W  = $clog2(IDLE_TIMEOUT) + 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(IDLE_TIMEOUT - 1);

   logic                  push_q;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ASM_W-1:0]      asm_q, asm_d;
   logic [TMR_W-1:0]      idle_q, idle_d;
   logic                  ovf_q, ovf_d;

   logic                  cap, last_byte, pop, wr_en;
   logic                  fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] wr_data, head;

   assign cap       = push_in & ~push_q;
   assign last_byte = cap & (idx_q == IDX_LAST);
   assign pop       = op_valid & op_ready;
   // A full FIFO still accepts the packet when the head leaves this cycle.
   assign wr_en     = last_byte & (~fifo_full | pop);
   assign wr_data   = {select, sign, asm_q, data_in_in};

   // Idle timer: down-counter reloaded on every capture; terminal count
   // abandons the partial packet (assembly bytes are simply overwritten).
   always_comb begin
      idx_d  = idx_q;
      asm_d  = asm_q;
      idle_d = idle_q;
      ovf_d  = ovf_q | (last_byte & ~wr_en);
      if (cap) begin
         asm_d  = {asm_q[ASM_W-BYTE_W-1:0], data_in_in};
         idle_d = TMR_LOAD;
         idx_d  = last_byte ? '0 : idx_q + 1'b1;
      end else if (idx_q != '0) begin
         if (idle_q == '0) begin
            idx_d = '0;
         end else begin
            idle_d = idle_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_q <= 1'b0;
         idx_q  <= '0;
         asm_q  <= '0;
         idle_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         push_q <= push_in;
         idx_q  <= idx_d;
         asm_q  <= asm_d;
         idle_q <= idle_d;
         ovf_q  <= ovf_d;
      end
   end

   div_op_fifo #(
      .DATA_WIDTH       (DATA_WIDTH),
      .BUFFER_DEPTH     (BUFFER_DEPTH),
      .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign op_valid    = ~fifo_empty;
   assign op_select   = head[2*WIDTH+1];
   assign op_sign     = head[2*WIDTH];
   assign op_dividend = head[2*WIDTH-1:WIDTH];
   assign op_divisor  = head[WIDTH-1:0];
   assign op_div_zero = (op_divisor == '0);
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_in_collector.sv
module tb_div_in_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_in_in;
   logic        push_in;
   logic        sign;
   logic        select;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_dividend;
   logic [31:0] op_divisor;
   logic        op_sign;
   logic        op_select;
   logic        op_div_zero;
   logic [2:0]  fifo_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [65:0] exp_q [$];
   logic [65:0] last_popped;

   always #5 clk = ~clk;

   div_in_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in_in  (data_in_in),
      .push_in     (push_in),
      .sign        (sign),
      .select      (select),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_dividend (op_dividend),
      .op_divisor  (op_divisor),
      .op_sign     (op_sign),
      .op_select   (op_select),
      .op_div_zero (op_div_zero),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [65:0] mk(input logic [31:0] dvd, input logic [31:0] dvs,
                                      input logic s, input logic sel);
      return {sel, s, dvd, dvs};
   endfunction

   function automatic logic [65:0] head();
      return {op_select, op_sign, op_dividend, op_divisor};
   endfunction

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      data_in_in = b;
      push_in    = 1'b1;
      repeat (hold) @(negedge clk);
      push_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [65:0] p, input int hold, input int nbytes);
      logic [63:0] ops;
      ops    = p[63:0];
      sign   = p[64];
      select = p[65];
      for (int i = 0; i < nbytes; i++) begin
         send_byte(ops[63-8*i -: 8], hold);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      checks++;
      if (op_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: valid=%b count=%0d ovf=%b want 0 0 0", op_valid, fifo_count, overflow);
      end
      checks++;
      if (head() !== 66'h0 || op_div_zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_head: head=%h dz=%b want 0 1", head(), op_div_zero);
      end
   endtask

   task automatic test_basic();
      logic [65:0] p;
      p = mk(32'h12345678, 32'h00000123, 1'b0, 1'b0);
      send_pkt(p, 1, 7);
      @(negedge clk);
      data_in_in = 8'h23;
      push_in    = 1'b1;
      checks++;
      if (op_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_valid: got %b want 0", op_valid);
      end
      exp_q.push_back(p);
      @(negedge clk);
      push_in = 1'b0;
      checks++;
      if (op_valid !== 1'b1 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL basic_latency: valid=%b count=%0d want 1 1", op_valid, fifo_count);
      end
      checks++;
      if (op_dividend !== 32'h12345678 || op_divisor !== 32'h00000123 || op_div_zero !== 1'b0) begin
         errors++;
         $display("FAIL basic_fields: dvd=%h dvs=%h dz=%b want 12345678 00000123 0",
                  op_dividend, op_divisor, op_div_zero);
      end
   endtask

   task automatic test_drain(input int n);
      logic [65:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL drain_model: scoreboard empty at pop %0d", i);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         if (op_valid !== 1'b1 || head() !== e) begin
            errors++;
            $display("FAIL drain_pkt%0d: valid=%b head=%h want 1 %h", i, op_valid, head(), e);
         end
         last_popped = e;
         op_ready = 1'b1;
         @(negedge clk);
         op_ready = 1'b0;
      end
      checks++;
      if (op_valid !== 1'b0 || fifo_count !== 3'd0 || head() !== last_popped) begin
         errors++;
         $display("FAIL drain_empty: valid=%b count=%0d head=%h want 0 0 %h",
                  op_valid, fifo_count, head(), last_popped);
      end
   endtask

   task automatic test_held();
      logic [65:0] p;
      p = mk(32'h12345678, 32'h00000123, 1'b0, 1'b0);
      send_pkt(p, 5, 8);
      exp_q.push_back(p);
      checks++;
      if (fifo_count !== 3'd1 || head() !== p) begin
         errors++;
         $display("FAIL held_pkt: count=%0d head=%h want 1 %h", fifo_count, head(), p);
      end
   endtask

   task automatic test_overflow();
      logic [65:0] p;
      for (int i = 0; i < 5; i++) begin
         p = mk(32'hA000_0000 + 32'(i * 32'h1111), 32'h0000_0100 + 32'(i), i[0], i[1]);
         send_pkt(p, 1, 8);
         if (exp_q.size() < 4) exp_q.push_back(p);
         checks++;
         if (fifo_count !== 3'(exp_q.size()) || overflow !== (i == 4)) begin
            errors++;
            $display("FAIL ovf_fill%0d: count=%0d ovf=%b want %0d %b",
                     i, fifo_count, overflow, exp_q.size(), (i == 4));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [65:0] p;
      logic [63:0] ops;
      for (int i = 0; i < 4; i++) begin
         p = mk(32'h5000_0000 | 32'(i), 32'h0F00_0000 | 32'(i), 1'b1, i[0]);
         send_pkt(p, 1, 8);
         exp_q.push_back(p);
      end
      p   = mk(32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1);
      ops = p[63:0];
      send_pkt(p, 1, 7);
      @(negedge clk);
      data_in_in = ops[7:0];
      push_in    = 1'b1;
      op_ready   = 1'b1;
      checks++;
      if (fifo_count !== 3'd4 || head() !== exp_q[0]) begin
         errors++;
         $display("FAIL b2b_pre: count=%0d head=%h want 4 %h", fifo_count, head(), exp_q[0]);
      end
      @(negedge clk);
      push_in  = 1'b0;
      op_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(p);
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_post: count=%0d ovf=%b want 4 0", fifo_count, overflow);
      end
   endtask

   task automatic test_idle();
      logic [65:0] p;
      send_pkt(mk(32'h99887766, 32'h0, 1'b0, 1'b0), 1, 3);
      repeat (64) @(negedge clk);
      p = mk(32'h01020304, 32'h05060708, 1'b1, 1'b0);
      send_pkt(p, 1, 8);
      exp_q.push_back(p);
      checks++;
      if (fifo_count !== 3'd1 || head() !== p) begin
         errors++;
         $display("FAIL idle_pkt: count=%0d head=%h want 1 %h", fifo_count, head(), p);
      end
   endtask

   task automatic test_div_zero_reset();
      logic [65:0] p;
      p = mk(32'h80000007, 32'h00000000, 1'b1, 1'b0);
      send_pkt(p, 1, 8);
      exp_q.push_back(p);
      checks++;
      if (op_valid !== 1'b1 || op_div_zero !== 1'b1 || op_sign !== 1'b1 || head() !== p) begin
         errors++;
         $display("FAIL divzero: valid=%b dz=%b sign=%b head=%h want 1 1 1 %h",
                  op_valid, op_div_zero, op_sign, head(), p);
      end
      send_pkt(mk(32'h11223344, 32'h55667788, 1'b0, 1'b0), 1, 3);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (op_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 ||
          head() !== 66'h0 || op_div_zero !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: valid=%b count=%0d ovf=%b head=%h dz=%b want 0 0 0 0 1",
                  op_valid, fifo_count, overflow, head(), op_div_zero);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      p = mk(32'h0BADF00D, 32'h00000042, 1'b0, 1'b1);
      send_pkt(p, 1, 8);
      exp_q.push_back(p);
      checks++;
      if (fifo_count !== 3'd1 || head() !== p) begin
         errors++;
         $display("FAIL post_reset_pkt: count=%0d head=%h want 1 %h", fifo_count, head(), p);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      data_in_in = 8'h00;
      push_in    = 1'b0;
      sign       = 1'b0;
      select     = 1'b0;
      op_ready   = 1'b0;
      last_popped = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_drain(1);
      test_held();
      test_drain(1);
      test_overflow();
      test_drain(4);
      do_reset();
      test_back_to_back();
      test_drain(4);
      test_idle();
      test_drain(1);
      test_div_zero_reset();
      test_drain(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
